// File: rtl/vga_mem_sched.sv
// vga_mem_sched: video memory arbiter, line burst fetch + host port.
// Ports: clk_p/rst, newline/newfield, h_* host, m_* memory, lb_* buffer.
module vga_mem_sched #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 40,
  parameter int LINES          = 480,
  parameter int MEM_LAT        = 2
) (
  input  logic              clk_p,
  input  logic              rst,
  input  logic              newline,
  input  logic              newfield,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [5:0]        lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              overrun
);

  localparam int LW = $clog2(LINES + 1);
  localparam int KW = 6;
  localparam int CW = $clog2(MEM_LAT + 2);

  localparam logic [LW-1:0] LINES_C = LW'(LINES);
  localparam logic [KW-1:0] K_LAST  = KW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] C_LAT   = CW'(MEM_LAT);
  localparam logic [CW-1:0] C_ACK   = CW'(MEM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, D_ISSUE, D_DRAIN, H_WR, H_RD
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [LW-1:0]       line_q, line_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                bank_q, bank_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // tag pipe: valid bit and word index per in-flight burst read
  logic [MEM_LAT-1:0]  tv_q;
  logic [KW-1:0]       ti_q [MEM_LAT];

  logic                issue;
  logic                last_wr;

  assign issue   = (state_q == D_ISSUE);
  assign last_wr = tv_q[MEM_LAT-1] &&
                   (ti_q[MEM_LAT-1] == K_LAST);

  always_ff @(posedge clk_p or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      line_q  <= LINES_C;
      base_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      base_q  <= base_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_p or negedge rst) begin
    if (!rst) begin
      tv_q <= '0;
      for (int i = 0; i < MEM_LAT; i++)
        ti_q[i] <= '0;
    end else begin
      tv_q[0] <= issue;
      ti_q[0] <= k_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        ti_q[i] <= ti_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    line_d  = line_q;
    base_d  = base_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ovr_d   = ovr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        k_d   = '0;
        cnt_d = '0;
        if (pend_q && (line_q < LINES_C)) begin
          bank_d  = ~bank_q;
          pend_d  = 1'b0;
          base_d  = ADDR_W'(32'(line_q) * WORDS_PER_LINE);
          state_d = D_ISSUE;
        end else if (pend_q) begin
          pend_d = 1'b0;
        end else if (h_req && !newline) begin
          // a newline this cycle will pend; let the burst go first
          state_d = h_we ? H_WR : H_RD;
        end
      end
      D_ISSUE: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) state_d = D_DRAIN;
      end
      D_DRAIN: begin
        if (last_wr) state_d = IDLE;
      end
      H_WR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q != '0) state_d = IDLE;
      end
      H_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAT) rdata_d = m_rdata;
        if (cnt_q == C_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (newline) begin
      pend_d = 1'b1;
      if (pend_q || issue || (state_q == D_DRAIN))
        ovr_d = 1'b1;
      else if (newfield)
        ovr_d = 1'b0;
      if (newfield)
        line_d = '0;
      else if (line_q >= LINES_C)
        line_d = LINES_C;
      else
        line_d = line_q + LW'(1);
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    h_ack   = 1'b0;
    unique case (state_q)
      D_ISSUE: begin
        m_en   = 1'b1;
        m_addr = base_q + ADDR_W'(k_q);
      end
      H_WR: begin
        if (cnt_q == '0) begin
          m_en    = 1'b1;
          m_we    = 1'b1;
          m_addr  = h_addr;
          m_wdata = h_wdata;
        end else begin
          h_ack = 1'b1;
        end
      end
      H_RD: begin
        if (cnt_q == '0) begin
          m_en   = 1'b1;
          m_addr = h_addr;
        end else if (cnt_q == C_ACK) begin
          h_ack = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign lb_we   = tv_q[MEM_LAT-1];
  assign lb_addr = lb_we ? ti_q[MEM_LAT-1] : '0;
  assign lb_data = lb_we ? m_rdata : '0;
  assign lb_bank = bank_q;
  assign overrun = ovr_q;
  assign h_rdata = rdata_q;

endmodule

// File: tb/tb_vga_mem_sched.sv
// tb_vga_mem_sched: scoreboard bench for vga_mem_sched.
// Expected memory/buffer/ack traffic queued by stimulus, checked by monitors.
module tb_vga_mem_sched;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPL = 40;
  localparam int LN  = 480;
  localparam int LAT = 2;

  logic          clk_p = 1'b0;
  logic          rst = 1'b0;
  logic          newline = 1'b0;
  logic          newfield = 1'b0;
  logic          h_req = 1'b0;
  logic          h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          lb_we;
  logic          lb_bank;
  logic [5:0]    lb_addr;
  logic [DW-1:0] lb_data;
  logic          overrun;

  always #5 clk_p = ~clk_p;

  vga_mem_sched #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL),
    .LINES(LN), .MEM_LAT(LAT)
  ) dut (
    .clk_p(clk_p), .rst(rst),
    .newline(newline), .newfield(newfield),
    .h_req(h_req), .h_we(h_we),
    .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank),
    .lb_addr(lb_addr), .lb_data(lb_data),
    .overrun(overrun)
  );

  function automatic logic [DW-1:0] f(int a);
    return DW'(a * 40503) ^ 16'h5A5A;
  endfunction

  // memory model with LAT-cycle read pipe
  logic [DW-1:0] mem [65536];
  logic [DW-1:0] rpipe [LAT];
  logic          init_q = 1'b0;

  always @(posedge clk_p) begin
    if (!init_q) begin
      for (int a = 0; a < 65536; a++) mem[a] <= f(a);
      init_q <= 1'b1;
    end else if (m_en && m_we) begin
      mem[m_addr] <= m_wdata;
    end
    rpipe[0] <= mem[m_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign m_rdata = rpipe[LAT-1];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } macc_t;
  typedef struct packed {
    logic          bank;
    logic [5:0]    addr;
    logic [DW-1:0] data;
  } lbw_t;
  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } ack_t;

  macc_t q_m[$];
  lbw_t  q_lb[$];
  ack_t  q_ack[$];

  logic [DW-1:0] shadow [int];
  int   n_tests = 0;
  int   n_fail = 0;
  logic exp_bank = 1'b0;
  int   exp_line = LN;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [DW-1:0] exp_word(int a);
    if (shadow.exists(a)) return shadow[a];
    return f(a);
  endfunction

  task automatic push_line(int line);
    macc_t m;
    lbw_t  l;
    if (line < LN) begin
      exp_bank = ~exp_bank;
      for (int k = 0; k < WPL; k++) begin
        m.we = 1'b0;
        m.addr = AW'(line * WPL + k);
        m.wdata = '0;
        q_m.push_back(m);
        l.bank = exp_bank;
        l.addr = 6'(k);
        l.data = exp_word(line * WPL + k);
        q_lb.push_back(l);
      end
    end
  endtask

  task automatic nl_model(bit nf);
    if (nf) exp_line = 0;
    else if (exp_line < LN) exp_line++;
    push_line(exp_line);
  endtask

  task automatic push_host(bit we, logic [AW-1:0] a,
                           logic [DW-1:0] d);
    macc_t m;
    ack_t  k;
    m.we = we;
    m.addr = a;
    m.wdata = we ? d : '0;
    q_m.push_back(m);
    k.rd = ~we;
    k.data = exp_word(int'(a));
    q_ack.push_back(k);
    if (we) shadow[int'(a)] = d;
  endtask

  // monitors
  always @(negedge clk_p) begin
    macc_t m;
    lbw_t  l;
    ack_t  k;
    if (rst) begin
      if (m_en) begin
        if (q_m.size() == 0) fail("m_en unexpected");
        else begin
          m = q_m.pop_front();
          check("m_we", m_we, m.we);
          check("m_addr", m_addr, m.addr);
          check("m_wdata", m_wdata, m.wdata);
        end
      end
      if (lb_we) begin
        if (q_lb.size() == 0) fail("lb_we unexpected");
        else begin
          l = q_lb.pop_front();
          check("lb_bank", lb_bank, l.bank);
          check("lb_addr", lb_addr, l.addr);
          check("lb_data", lb_data, l.data);
        end
      end
      if (h_ack) begin
        if (q_ack.size() == 0) fail("h_ack unexpected");
        else begin
          k = q_ack.pop_front();
          if (k.rd) check("h_rdata", h_rdata, k.data);
        end
      end
    end
  end

  task automatic pulse_nl(bit nf);
    @(posedge clk_p); #1;
    newline = 1'b1;
    newfield = nf;
    nl_model(nf);
    @(posedge clk_p); #1;
    newline = 1'b0;
    newfield = 1'b0;
  endtask

  task automatic host(bit we, logic [AW-1:0] a,
                      logic [DW-1:0] d, int lat_exp,
                      string nm);
    int lat = -1;
    @(posedge clk_p); #1;
    h_req = 1'b1;
    h_we = we;
    h_addr = a;
    h_wdata = d;
    push_host(we, a, d);
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clk_p);
      if (h_ack) lat = i;
    end
    if (lat < 0) fail({nm, " ack timeout"});
    else check(nm, lat, lat_exp);
    @(posedge clk_p); #1;
    h_req = 1'b0;
  endtask

  task automatic count_act(int n, output int cm,
                           output int cl);
    cm = 0;
    cl = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_p);
      if (m_en) cm++;
      if (lb_we) cl++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fm, lm, fl, nm, lat, cm, cl;
    bit found;
    repeat (3) @(posedge clk_p);
    #1;
    check("rst m_en", m_en, 0);
    check("rst lb_we", lb_we, 0);
    check("rst h_ack", h_ack, 0);
    check("rst lb_bank", lb_bank, 0);
    check("rst overrun", overrun, 0);
    @(negedge clk_p);
    rst = 1'b1;

    // field start: first burst with timing
    @(posedge clk_p); #1;
    newline = 1'b1;
    newfield = 1'b1;
    nl_model(1);
    fm = -1; lm = -1; fl = -1; nm = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_p);
      if (m_en) begin
        nm++;
        lm = i;
        if (fm < 0) fm = i;
      end
      if (lb_we && fl < 0) fl = i;
      if (i == 0) begin
        @(posedge clk_p); #1;
        newline = 1'b0;
        newfield = 1'b0;
      end
    end
    check("first issue", fm, 2);
    check("issue count", nm, WPL);
    check("issue span", lm - fm, WPL - 1);
    check("lb latency", fl - fm, LAT);
    check("bank l0", lb_bank, 1);
    check("ovr l0", overrun, 0);

    pulse_nl(0);
    repeat (50) @(posedge clk_p);
    check("bank l1", lb_bank, 0);

    host(1, 16'h1234, 16'hBEEF, 2, "wr lat");
    host(0, 16'h1234, 16'h0000, 2 + LAT, "rd lat");

    // newline and host write in the same idle cycle
    @(posedge clk_p); #1;
    newline = 1'b1;
    nl_model(0);
    h_req = 1'b1;
    h_we = 1'b1;
    h_addr = 16'h0055;
    h_wdata = 16'h1357;
    push_host(1, 16'h0055, 16'h1357);
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clk_p);
      if (h_ack) lat = i;
      if (i == 0) begin
        @(posedge clk_p); #1;
        newline = 1'b0;
      end
    end
    if (lat < 0) fail("prio ack timeout");
    else check("prio lat", lat, 4 + WPL + LAT);
    @(posedge clk_p); #1;
    h_req = 1'b0;
    host(0, 16'h0055, 16'h0000, 2 + LAT, "rd back");

    // overrun: second newline mid-burst
    pulse_nl(0);
    repeat (10) @(posedge clk_p);
    pulse_nl(0);
    repeat (120) @(posedge clk_p);
    check("ovr set", overrun, 1);
    pulse_nl(0);
    repeat (60) @(posedge clk_p);
    check("ovr sticky", overrun, 1);
    pulse_nl(1);
    check("ovr clear", overrun, 0);
    repeat (46) @(posedge clk_p);

    // sweep the field; line LN and beyond never fetch
    for (int n = 1; n < LN; n++) begin
      pulse_nl(0);
      repeat (46) @(posedge clk_p);
    end
    pulse_nl(0);
    count_act(50, cm, cl);
    check("no fetch 480", cm, 0);
    pulse_nl(0);
    count_act(50, cm, cl);
    check("no fetch sat", cm, 0);
    check("ovr sweep", overrun, 0);
    check("q_lb drained", q_lb.size(), 0);

    // reset in the middle of a burst
    pulse_nl(1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_p);
      if (m_en && m_addr == 16'd20) found = 1'b1;
    end
    if (!found) fail("k20 timeout");
    #2;
    rst = 1'b0;
    #1;
    check("mrst m_en", m_en, 0);
    check("mrst m_addr", m_addr, 0);
    check("mrst lb_we", lb_we, 0);
    check("mrst lb_data", lb_data, 0);
    check("mrst lb_bank", lb_bank, 0);
    check("mrst h_ack", h_ack, 0);
    check("mrst h_rdata", h_rdata, 0);
    q_m.delete();
    q_lb.delete();
    q_ack.delete();
    exp_bank = 1'b0;
    exp_line = LN;
    repeat (2) @(negedge clk_p);
    #1;
    rst = 1'b1;
    count_act(30, cm, cl);
    check("post rst lb_we", cl, 0);
    check("post rst m_en", cm, 0);
    pulse_nl(0);
    count_act(50, cm, cl);
    check("no field no fetch", cm, 0);
    pulse_nl(1);
    repeat (60) @(posedge clk_p);
    check("bank after rst", lb_bank, 1);

    check("q_m empty", q_m.size(), 0);
    check("q_lb empty", q_lb.size(), 0);
    check("q_ack empty", q_ack.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mem_sched.md
Name: vga_mem_sched

Overview:
- Scheduler for the single-port video memory shared by the display path and a host port.
- On each line-start pulse from the VGA timing generator, it bursts one line of pixel words from memory into a ping-pong line buffer.
- Between bursts it services single-word host reads and writes through a req/ack handshake.
- Display fetch has strict priority over the host.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 16, memory and host data width
- WORDS_PER_LINE, 40, words fetched per line (640 px at 1 bpp / 16 bits)
- LINES, 480, visible lines; fetch is skipped when the line index is LINES or greater
- MEM_LAT, 2, read latency: m_rdata is valid MEM_LAT cycles after an m_en read cycle (MEM_LAT of 1 or more)

Ports:
- clk_p  in  1  pixel clock
- rst  in  1  asynchronous reset, active low
- newline  in  1  one-cycle pulse at line start, from the timing generator
- newfield  in  1  level, high throughout line 0 of a field
- h_req  in  1  host request; held until h_ack
- h_we  in  1  1 = write, 0 = read; stable while h_req is high
- h_addr  in  ADDR_W  host word address
- h_wdata  in  DATA_W  host write data
- h_ack  out  1  one-cycle completion pulse
- h_rdata  out  DATA_W  read data, valid with h_ack
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- lb_we  out  1  line-buffer write strobe
- lb_bank  out  1  bank being filled; toggles at each fetch start
- lb_addr  out  6  word index within the line
- lb_data  out  DATA_W  line-buffer write data
- overrun  out  1  sticky: newline arrived while a fetch was still in progress

Behaviour:
- Reset (rst low, async):
  - All outputs 0.
  - State IDLE.
  - fetch_line = LINES (so no fetch until a field start).
  - Pending flag cleared.
- States: IDLE, D_ISSUE, D_DRAIN, H_WR, H_RD.
- Fetch trigger (sampled in any state):
  - A newline pulse sets pend.
  - If newfield=1 in the same cycle, fetch_line := 0; otherwise fetch_line := fetch_line+1, saturating at LINES.
  - If pend is already set, or the state is D_ISSUE or D_DRAIN, overrun := 1.
- IDLE:
  - If pend=1 and fetch_line < LINES: toggle lb_bank, clear pend, base := fetch_line*WORDS_PER_LINE (ADDR_W truncation), go to D_ISSUE.
  - Else if pend=1: clear pend, stay in IDLE.
  - Else if h_req=1: go to H_WR or H_RD according to h_we.
  - pend wins over h_req in the same cycle.
- D_ISSUE:
  - m_en=1, m_we=0, m_addr=base+k for k = 0..WORDS_PER_LINE-1, one per cycle.
  - After the last address is issued, go to D_DRAIN.
- Read return path:
  - A shift pipe of depth MEM_LAT tags the returning words.
  - lb_we=1, lb_addr=k, lb_data=m_rdata exactly MEM_LAT cycles after issue k.
- D_DRAIN:
  - Wait until the last tagged word has been written, then go to IDLE.
  - Burst duration: WORDS_PER_LINE+MEM_LAT cycles from the first issue.
- H_WR:
  - One cycle with m_en=1, m_we=1, m_addr=h_addr, m_wdata=h_wdata.
  - h_ack=1 on the next cycle, then IDLE.
  - Host write latency: 2 cycles from IDLE acceptance to ack.
- H_RD:
  - One cycle with m_en=1, m_we=0.
  - After MEM_LAT cycles, h_rdata := m_rdata (registered) and h_ack=1 on the following cycle, then IDLE.
  - A newline during a host operation only sets pend; the host operation completes first.
- h_ack is high for exactly one cycle.
  - A host that keeps h_req high after ack is re-served as a new request.
- overrun clears only on a newline with newfield=1 (field start) or on reset.
  - A field-start newline that itself overruns sets overrun again.
- Reset mid-burst:
  - Outputs drop to 0 immediately.
  - In-flight read tags are discarded; no lb_we occurs after reset.

Test Plan:
- Reset, then newline with newfield=1 → lb_bank goes to 1; m_addr 0..39 on 40 consecutive cycles; lb_we at addr 0..39 starting 2 cycles later; lb_data equals the model memory; overrun=0.
- Next newline with newfield=0 → m_addr 40..79; lb_bank goes to 0.
- h_req write (addr 0x1234, data 0xBEEF) in IDLE → m_en/m_we for 1 cycle, h_ack 2 cycles after acceptance. A following read of 0x1234 returns h_rdata=0xBEEF with h_ack on cycle 1+MEM_LAT+1.
- h_req and newline together in IDLE → the burst runs first; h_ack only after D_DRAIN completes; the host write lands intact.
- Second newline injected 10 cycles into a burst → overrun=1, stays 1 through later lines, clears at the next field-start newline.
- 481 newlines after field start → no m_en for fetch_line ≥ 480.
- rst asserted mid-burst at k=20 → all outputs 0 that cycle; no lb_we after release until the next newline.
